rtc_scheduler: RTL and testbench
================================

# rtc_scheduler

Sequences all accesses to the I2C real-time-clock core (mcp7940n instance) and keeps a coherent datetime shadow for the rest of the system. CPU register writes (set time/date fields) are queued, issued to the core one at a time, and each is retired only when the core completes a full I2C sweep, signalled by its `tick`. In parallel the block latches every `datetime` update, flags a stalled RTC, and gives software an atomic snapshot. It sits between the CPU I/O decode and the RTC core wrapper.

## Interface
Parameters:
- `DEPTH_LOG2`, 2: write-queue depth = 2^DEPTH_LOG2 entries.
- `TIMEOUT_CYCLES`, 50000000: max cycles from issue to retiring `tick` (2 s at 25 MHz).
- `STALE_CYCLES`, 37500000: cycles without any `tick` before `rtc_stale` asserts.

Ports:
- `clk` in 1: system clock, 25 MHz.
- `reset` in 1: synchronous, active-low; 0 = reset on the next `clk` edge.
- `cpu_wr` in 1: one-cycle write strobe.
- `cpu_addr` in 3: RTC field index (0 = SS … 6 = YY).
- `cpu_data` in 8: BCD field value.
- `cpu_snap` in 1: one-cycle strobe; copies shadow into `snap_datetime`.
- `cpu_busy` out 1: queue full or a write is in flight.
- `rtc_wr` out 1: one-cycle write command to the core.
- `rtc_addr` out 3, `rtc_data` out 8: command fields, held stable from issue until retire.
- `rtc_tick` in 1: core sweep-complete pulse.
- `rtc_datetime` in 56: core BCD `{YY,MM,DD,WD,HH,MM,SS}`.
- `datetime` out 56: live shadow, updated on every tick.
- `snap_datetime` out 56: software snapshot.
- `datetime_valid` out 1: at least one tick seen since reset.
- `rtc_stale` out 1: no tick for `STALE_CYCLES`.
- `err_timeout` out 1: sticky; a write was dropped on timeout.
- `err_overflow` out 1: sticky; a `cpu_wr` arrived while the queue was full.
- `err_clr` in 1: one-cycle strobe; clears all sticky errors.

## Operation
- Write queue: FIFO of {addr, data}, 2^DEPTH_LOG2 entries.
  - Push on `cpu_wr` when not full. When full, the write is dropped and `err_overflow` sets, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into the command registers and go to ISSUE.
  - ISSUE: `rtc_wr`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: the first `rtc_tick` in this state retires the command and returns to IDLE. If the counter reaches `TIMEOUT_CYCLES`, set `err_timeout`, drop the command and return to IDLE.
  - A tick arriving in the ISSUE cycle does not retire the command; only a tick in WAIT does.
- Shadow: `datetime <= rtc_datetime` on every `rtc_tick`, in any state. `datetime_valid` sets on the first tick.
- Stale detection: a 26-bit counter clears on tick and increments otherwise, saturating at `STALE_CYCLES`. `rtc_stale` = (counter == `STALE_CYCLES`).
- Snapshot: `snap_datetime <= datetime` on `cpu_snap`. If `cpu_snap` and `rtc_tick` occur in the same cycle, the snapshot takes the new `rtc_datetime` (bypass), so it is never a mixed value.
- Errors: `err_clr` clears the sticky errors. If `err_clr` and a set event occur in the same cycle, set wins.
- `cpu_busy` = queue full OR state ≠ IDLE.

## Timing
- Reset values:
  - Outputs: all 0, including `rtc_addr`, `rtc_data`, `datetime`, `snap_datetime`, `datetime_valid`, `rtc_stale` and the errors.
  - Internal: queue empty; FSM in IDLE; all counters 0.
- Reset mid-WAIT aborts the command silently, with no error.
- Latency: `cpu_wr` into an empty queue with FSM in IDLE → `rtc_wr` pulses 2 cycles later (cycle 0 push, cycle 1 IDLE pop, cycle 2 ISSUE).
- Back-to-back issue: the minimum gap between `rtc_wr` pulses is retire + 2 cycles.
- Shadow and snapshot registers update on the cycle after the strobe; they are registered, not combinational.
- Counter widths must hold `max(TIMEOUT_CYCLES, STALE_CYCLES)`; 26 bits at the defaults.

## Configuration
- `RTC_SCHED_BCD_CHECK_EN` defined:
  - At push, any nibble > 9, or `cpu_addr` = 7, rejects the write: it is not queued and `err_bcd` (an extra sticky output, cleared by `err_clr`) sets.
- `RTC_SCHED_BCD_CHECK_EN` undefined:
  - No check; every write is queued.
  - The `err_bcd` port is absent.

## Test plan
- Single write: reset, `cpu_wr` addr=2 data=8'h23 → `rtc_wr` pulses 2 cycles later with addr=2, data=8'h23. `cpu_busy`=1 until a tick in WAIT, then 0.
- Overflow (DEPTH_LOG2=2): 6 consecutive `cpu_wr` with no ticks → first pops to ISSUE, 4 queued, 6th dropped, `err_overflow`=1. Then 5 ticks → `rtc_wr` sequence matches pushes 1–5 in order.
- Timeout (TIMEOUT_CYCLES=100): one write, no ticks → `err_timeout`=1 at cycle 100 of WAIT; the next queued write issues 2 cycles later.
- Stale/valid (STALE_CYCLES=50): no ticks → `rtc_stale`=1 at cycle 50. One tick with datetime 56'h24_06_15_06_12_30_45 → `rtc_stale`=0, `datetime_valid`=1, `datetime` equals that value.
- Snapshot bypass: `cpu_snap` and `rtc_tick` in the same cycle with new value 56'h…_46 → `snap_datetime` = new value.
- BCD check (macro on): `cpu_wr` data=8'h3A → not queued, `err_bcd`=1, no `rtc_wr`.

Source files
------------

// File: rtl/rtc_scheduler.sv
// rtc_scheduler: serialises CPU writes to the RTC core and keeps a datetime
// shadow with stale detection, atomic snapshot and sticky error flags.
// Ports:
//   clk, reset (sync, active-low)
//   cpu_wr/cpu_addr/cpu_data : field write into the queue
//   cpu_snap                 : copy shadow into snap_datetime
//   cpu_busy                 : queue full or a write in flight
//   rtc_wr/rtc_addr/rtc_data : command to the core, held until retire
//   rtc_tick/rtc_datetime    : sweep-complete pulse and core datetime
//   datetime, snap_datetime  : live shadow and software snapshot
//   datetime_valid, rtc_stale
//   err_timeout, err_overflow (sticky), err_clr
// Optional: RTC_SCHED_BCD_CHECK_EN adds BCD/address validation at push
//   and the sticky err_bcd output.
module rtc_scheduler #(
  parameter int DEPTH_LOG2     = 2,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int STALE_CYCLES   = 37500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_snap,
  output logic        cpu_busy,
  output logic        rtc_wr,
  output logic [2:0]  rtc_addr,
  output logic [7:0]  rtc_data,
  input  logic        rtc_tick,
  input  logic [55:0] rtc_datetime,
  output logic [55:0] datetime,
  output logic [55:0] snap_datetime,
  output logic        datetime_valid,
  output logic        rtc_stale,
  output logic        err_timeout,
  output logic        err_overflow,
`ifdef RTC_SCHED_BCD_CHECK_EN
  output logic        err_bcd,
`endif
  input  logic        err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CMAX  = (TIMEOUT_CYCLES > STALE_CYCLES) ?
                         TIMEOUT_CYCLES : STALE_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STL      = CW'(STALE_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Queue: one extra pointer bit separates full from empty.
  logic [10:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                q_full, q_empty;
  logic                bcd_bad;
  logic                push, pop;
  logic                ovf_set;

  logic                issue;
  logic                tmo_hit;
  logic [CW-1:0]       tmo_cnt;
  logic [CW-1:0]       stale_cnt;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

`ifdef RTC_SCHED_BCD_CHECK_EN
  assign bcd_bad = (cpu_data[3:0] > 4'd9) ||
                   (cpu_data[7:4] > 4'd9) ||
                   (cpu_addr == 3'd7);
`else
  assign bcd_bad = 1'b0;
`endif

  // Fullness is judged before any same-cycle pop, so a write
  // arriving on a full queue is always dropped.
  assign push    = cpu_wr && !q_full && !bcd_bad;
  assign ovf_set = cpu_wr && q_full && !bcd_bad;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (rtc_tick) begin
          state_d = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rtc_wr    = issue;
  assign cpu_busy  = q_full || (state_q != IDLE);
  assign rtc_stale = (stale_cnt == STL);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {cpu_addr, cpu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rtc_addr <= '0;
      rtc_data <= '0;
    end else if (pop) begin
      {rtc_addr, rtc_data} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

  // Counts WAIT cycles; restarted by each issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (issue) begin
      tmo_cnt <= '0;
    end else if (state_q == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stale_cnt <= '0;
    end else if (rtc_tick) begin
      stale_cnt <= '0;
    end else if (stale_cnt != STL) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      datetime       <= '0;
      datetime_valid <= 1'b0;
    end else if (rtc_tick) begin
      datetime       <= rtc_datetime;
      datetime_valid <= 1'b1;
    end
  end

  // A snapshot coinciding with a tick takes the incoming value so it
  // never mixes old and new fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_datetime <= '0;
    end else if (cpu_snap) begin
      snap_datetime <= rtc_tick ? rtc_datetime : datetime;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_timeout  <= tmo_hit | (err_timeout & ~err_clr);
      err_overflow <= ovf_set | (err_overflow & ~err_clr);
    end
  end

`ifdef RTC_SCHED_BCD_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_bcd <= 1'b0;
    end else begin
      err_bcd <= (cpu_wr & bcd_bad) | (err_bcd & ~err_clr);
    end
  end
`endif

endmodule

// File: tb/tb_rtc_scheduler.sv
// tb_rtc_scheduler: directed bench for rtc_scheduler with short
// timeout/stale parameters.
module tb_rtc_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [2:0]  cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_snap = 1'b0;
  logic        cpu_busy;
  logic        rtc_wr;
  logic [2:0]  rtc_addr;
  logic [7:0]  rtc_data;
  logic        rtc_tick = 1'b0;
  logic [55:0] rtc_datetime = '0;
  logic [55:0] datetime;
  logic [55:0] snap_datetime;
  logic        datetime_valid;
  logic        rtc_stale;
  logic        err_timeout;
  logic        err_overflow;
`ifdef RTC_SCHED_BCD_CHECK_EN
  logic        err_bcd;
`endif
  logic        err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  rtc_scheduler #(
    .DEPTH_LOG2(2),
    .TIMEOUT_CYCLES(100),
    .STALE_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .cpu_snap(cpu_snap),
    .cpu_busy(cpu_busy),
    .rtc_wr(rtc_wr),
    .rtc_addr(rtc_addr),
    .rtc_data(rtc_data),
    .rtc_tick(rtc_tick),
    .rtc_datetime(rtc_datetime),
    .datetime(datetime),
    .snap_datetime(snap_datetime),
    .datetime_valid(datetime_valid),
    .rtc_stale(rtc_stale),
    .err_timeout(err_timeout),
    .err_overflow(err_overflow),
`ifdef RTC_SCHED_BCD_CHECK_EN
    .err_bcd(err_bcd),
`endif
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next rtc_wr pulse and checks its fields
  // and how many cycles it took to appear.
  task automatic wait_wr(input string tag,
                         input logic [2:0] a,
                         input logic [7:0] d,
                         input int gap);
    int n = 0;
    while (rtc_wr !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 64'(rtc_wr), 64'd1);
    chk({tag, "_gap"}, 64'(n), 64'(gap));
    chk({tag, "_addr"}, 64'(rtc_addr), 64'(a));
    chk({tag, "_data"}, 64'(rtc_data), 64'(d));
  endtask

  task automatic tick(input logic [55:0] v);
    rtc_datetime = v;
    rtc_tick = 1'b1;
    step();
    rtc_tick = 1'b0;
  endtask

  initial begin
    int seen;
    logic [7:0] ov_data [6];
    ov_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    // Reset state
    step(); step(); step();
    chk("rst_busy", 64'(cpu_busy), 64'd0);
    chk("rst_wr", 64'(rtc_wr), 64'd0);
    chk("rst_addr", 64'(rtc_addr), 64'd0);
    chk("rst_data", 64'(rtc_data), 64'd0);
    chk("rst_dt", 64'(datetime), 64'd0);
    chk("rst_snap", 64'(snap_datetime), 64'd0);
    chk("rst_valid", 64'(datetime_valid), 64'd0);
    chk("rst_stale", 64'(rtc_stale), 64'd0);
    chk("rst_etmo", 64'(err_timeout), 64'd0);
    chk("rst_eovf", 64'(err_overflow), 64'd0);

    // Stale: 49 idle cycles not yet stale, 50th asserts it
    reset = 1'b1;
    repeat (49) step();
    chk("stale_49", 64'(rtc_stale), 64'd0);
    step();
    chk("stale_50", 64'(rtc_stale), 64'd1);
    chk("valid_pre", 64'(datetime_valid), 64'd0);
    tick(56'h24_06_15_06_12_30_45);
    chk("stale_clr", 64'(rtc_stale), 64'd0);
    chk("valid_set", 64'(datetime_valid), 64'd1);
    chk("dt_first", 64'(datetime), 64'h24_06_15_06_12_30_45);

    // Single write, with a tick in ISSUE that must not retire it
    cpu_wr = 1'b1; cpu_addr = 3'd2; cpu_data = 8'h23;
    step();
    cpu_wr = 1'b0;
    chk("sw_c1_wr", 64'(rtc_wr), 64'd0);
    step();
    chk("sw_c2_wr", 64'(rtc_wr), 64'd1);
    chk("sw_addr", 64'(rtc_addr), 64'd2);
    chk("sw_data", 64'(rtc_data), 64'h23);
    chk("sw_busy", 64'(cpu_busy), 64'd1);
    tick(56'h24_06_15_06_12_30_50);
    chk("sw_issue_tick_busy", 64'(cpu_busy), 64'd1);
    chk("sw_wr_one", 64'(rtc_wr), 64'd0);
    chk("sw_dt_issue", 64'(datetime), 64'h24_06_15_06_12_30_50);
    step(); step();
    chk("sw_hold_addr", 64'(rtc_addr), 64'd2);
    chk("sw_hold_busy", 64'(cpu_busy), 64'd1);
    tick(56'h24_06_15_06_12_30_51);
    chk("sw_retire_busy", 64'(cpu_busy), 64'd0);

    // Timeout: two writes, the first never gets a tick
    cpu_wr = 1'b1; cpu_addr = 3'd0; cpu_data = 8'h11;
    step();
    cpu_addr = 3'd1; cpu_data = 8'h22;
    step();
    cpu_wr = 1'b0;
    chk("to_a_wr", 64'(rtc_wr), 64'd1);
    chk("to_a_data", 64'(rtc_data), 64'h11);
    repeat (100) step();
    chk("to_99", 64'(err_timeout), 64'd0);
    step();
    chk("to_100", 64'(err_timeout), 64'd1);
    step();
    chk("to_b_wr", 64'(rtc_wr), 64'd1);
    chk("to_b_addr", 64'(rtc_addr), 64'd1);
    chk("to_b_data", 64'(rtc_data), 64'h22);
    step();
    tick(56'h24_06_15_06_12_31_00);
    chk("to_b_retire", 64'(cpu_busy), 64'd0);
    chk("to_sticky", 64'(err_timeout), 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_clr", 64'(err_timeout), 64'd0);

    // Overflow: 6 back-to-back writes, err_clr coincides with drop
    for (int i = 0; i < 6; i++) begin
      cpu_wr = 1'b1;
      cpu_addr = 3'(i);
      cpu_data = ov_data[i];
      err_clr = (i == 5);
      step();
      if (i == 1) begin
        chk("ov_first_wr", 64'(rtc_wr), 64'd1);
        chk("ov_first_data", 64'(rtc_data), 64'h01);
      end
      if (i == 4) chk("ov_not_yet", 64'(err_overflow), 64'd0);
    end
    cpu_wr = 1'b0;
    err_clr = 1'b0;
    chk("ov_set_wins", 64'(err_overflow), 64'd1);
    chk("ov_busy_full", 64'(cpu_busy), 64'd1);
    for (int i = 1; i < 5; i++) begin
      tick(56'h24_06_15_06_12_32_00);
      wait_wr($sformatf("ov_seq%0d", i), 3'(i), ov_data[i], 1);
      step();
    end
    tick(56'h24_06_15_06_12_32_10);
    seen = 0;
    repeat (6) begin
      if (rtc_wr === 1'b1) seen++;
      step();
    end
    chk("ov_sixth_dropped", 64'(seen), 64'd0);
    chk("ov_idle_busy", 64'(cpu_busy), 64'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ov_clr", 64'(err_overflow), 64'd0);

    // Snapshot: plain copy, then bypass on a coincident tick
    rtc_datetime = 56'h99_99_99_99_99_99_99;
    cpu_snap = 1'b1;
    step();
    cpu_snap = 1'b0;
    chk("snap_plain", 64'(snap_datetime), 64'h24_06_15_06_12_32_10);
    cpu_snap = 1'b1;
    tick(56'h24_06_15_06_12_30_46);
    cpu_snap = 1'b0;
    chk("snap_bypass", 64'(snap_datetime), 64'h24_06_15_06_12_30_46);
    chk("snap_dt", 64'(datetime), 64'h24_06_15_06_12_30_46);

    // Reset mid-WAIT: command aborted with no error
    cpu_wr = 1'b1; cpu_addr = 3'd5; cpu_data = 8'h07;
    step();
    cpu_wr = 1'b0;
    step(); step(); step();
    chk("rw_busy_pre", 64'(cpu_busy), 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rw_busy", 64'(cpu_busy), 64'd0);
    chk("rw_addr", 64'(rtc_addr), 64'd0);
    chk("rw_dt", 64'(datetime), 64'd0);
    seen = 0;
    repeat (120) begin
      if (rtc_wr === 1'b1) seen++;
      step();
    end
    chk("rw_no_issue", 64'(seen), 64'd0);
    chk("rw_no_err", 64'(err_timeout), 64'd0);

`ifdef RTC_SCHED_BCD_CHECK_EN
    cpu_wr = 1'b1; cpu_addr = 3'd1; cpu_data = 8'h3A;
    step();
    cpu_wr = 1'b0;
    seen = 0;
    repeat (4) begin
      if (rtc_wr === 1'b1) seen++;
      step();
    end
    chk("bcd_no_wr", 64'(seen), 64'd0);
    chk("bcd_err", 64'(err_bcd), 64'd1);
    chk("bcd_busy", 64'(cpu_busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
